// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor controller.
// Latency: n/a (types, constants and a pure function).
// Backpressure: n/a.
package bp_pkg;

  // 2-bit saturating counter encodings; bit 1 is the taken prediction
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Index width carried in a queue entry; the top-level IDX_W must match it
  localparam int BP_IDX_W = 4;

  // One outstanding prediction: which counter it came from and what it said
  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic                pred;
  } bp_entry_t;

  // Saturating counter step towards the resolved outcome
  function automatic logic [1:0] bp_next_state(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    nxt = state;
    case (state)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = state;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_pred_fifo.sv
// In-order queue of outstanding predictions; clear wins over push.
// Latency: push visible at head / in count one edge later; head is a combinational read.
// Backpressure: none internally; caller must not push when count == Q_DEPTH.
module bp_pred_fifo
  import bp_pkg::*;
#(
  parameter int Q_DEPTH = 4,
  parameter int CNT_W   = $clog2(Q_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  bp_entry_t        push_entry,
  input  logic             pop,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output bp_entry_t        head_entry
);

  localparam int PTR_W = $clog2(Q_DEPTH);

  bp_entry_t        mem [Q_DEPTH];
  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count_q;

  // Entry storage needs no reset: validity is tracked by count
  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail_ptr] <= push_entry;
  end

  // Pointers wrap naturally at the power-of-two depth; full/empty come from count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else if (clear) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count_q  <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign count      = count_q;
  assign head_entry = mem[head_ptr];

endmodule

// File: rtl/branch_predict_ctrl.sv
// 2-bit saturating predictor table with in-order resolve queue and mispredict flush.
// Latency: prediction 0 cycles; flush/err pulses and counter updates 1 cycle after resolve.
// Backpressure: lookup_ready_o drops when Q_DEPTH predictions are outstanding.
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int         IDX_W      = BP_IDX_W,
  parameter int         Q_DEPTH    = 4,
  parameter logic [1:0] INIT_STATE = ST
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       lookup_valid_i,
  input  logic [IDX_W-1:0]           lookup_idx_i,
  output logic                       lookup_ready_o,
  output logic                       predict_o,
  input  logic                       resolve_valid_i,
  input  logic                       resolve_taken_i,
  output logic                       flush_o,
  output logic                       flush_taken_o,
  output logic                       resolve_err_o,
  output logic [$clog2(Q_DEPTH):0]   queue_count_o,
  output logic [15:0]                mispredict_cnt_o
);

  localparam int CNT_W   = $clog2(Q_DEPTH) + 1;
  localparam int ENTRIES = 2 ** IDX_W;

  logic [1:0]       ctr [ENTRIES];
  logic [CNT_W-1:0] count;
  bp_entry_t        head;
  bp_entry_t        new_entry;
  logic             push;
  logic             pop;
  logic             mispredict;
  logic             flush_q;
  logic             flush_taken_q;
  logic             err_q;
  logic [15:0]      mp_cnt_q;

  // Lookup/resolve handshakes; ready looks only at the registered count, so a
  // full queue refuses a push even while the head is being resolved
  always_comb begin
    lookup_ready_o = (count < CNT_W'(Q_DEPTH));
    predict_o      = ctr[lookup_idx_i][1];
    push           = lookup_valid_i && lookup_ready_o;
    pop            = resolve_valid_i && (count != '0);
    mispredict     = pop && (head.pred != resolve_taken_i);
    new_entry.idx  = lookup_idx_i;
    new_entry.pred = predict_o;
  end

  bp_pred_fifo #(
    .Q_DEPTH (Q_DEPTH),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .push       (push),
    .push_entry (new_entry),
    .pop        (pop),
    .clear      (mispredict),
    .count      (count),
    .head_entry (head)
  );

  // Train the resolved counter; younger discarded entries never touch the table
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= INIT_STATE;
    end else if (pop) begin
      ctr[head.idx] <= bp_next_state(ctr[head.idx], resolve_taken_i);
    end
  end

  // Registered pulses toward pipeline control and the saturating mispredict count
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      flush_q       <= 1'b0;
      flush_taken_q <= 1'b0;
      err_q         <= 1'b0;
      mp_cnt_q      <= '0;
    end else begin
      flush_q       <= mispredict;
      flush_taken_q <= mispredict && resolve_taken_i;
      err_q         <= resolve_valid_i && (count == '0);
      if (mispredict && (mp_cnt_q != 16'hFFFF)) mp_cnt_q <= mp_cnt_q + 16'd1;
    end
  end

  assign flush_o          = flush_q;
  assign flush_taken_o    = flush_taken_q;
  assign resolve_err_o    = err_q;
  assign queue_count_o    = count;
  assign mispredict_cnt_o = mp_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with hand-computed expectations.
// Latency: inputs driven just after a rising edge, outputs sampled 1 time unit after the next.
// Backpressure: exercised by filling the queue and offering extra lookups.
module tb_branch_predict_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lookup_valid_i;
  logic [3:0]  lookup_idx_i;
  logic        lookup_ready_o;
  logic        predict_o;
  logic        resolve_valid_i;
  logic        resolve_taken_i;
  logic        flush_o;
  logic        flush_taken_o;
  logic        resolve_err_o;
  logic [2:0]  queue_count_o;
  logic [15:0] mispredict_cnt_o;

  int tests  = 0;
  int errors = 0;

  branch_predict_ctrl #(
    .IDX_W      (4),
    .Q_DEPTH    (4),
    .INIT_STATE (2'b11)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .lookup_valid_i   (lookup_valid_i),
    .lookup_idx_i     (lookup_idx_i),
    .lookup_ready_o   (lookup_ready_o),
    .predict_o        (predict_o),
    .resolve_valid_i  (resolve_valid_i),
    .resolve_taken_i  (resolve_taken_i),
    .flush_o          (flush_o),
    .flush_taken_o    (flush_taken_o),
    .resolve_err_o    (resolve_err_o),
    .queue_count_o    (queue_count_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus and let combinational outputs settle
  task automatic drive(input logic lv, input logic [3:0] li, input logic rv, input logic rt);
    lookup_valid_i  = lv;
    lookup_idx_i    = li;
    resolve_valid_i = rv;
    resolve_taken_i = rt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [2:0] cnt, input logic [15:0] mp);
    check({tag, "_flush"}, 32'(flush_o), 32'd0);
    check({tag, "_err"},   32'(resolve_err_o), 32'd0);
    check({tag, "_count"}, 32'(queue_count_o), 32'(cnt));
    check({tag, "_mpcnt"}, 32'(mispredict_cnt_o), 32'(mp));
  endtask

  initial begin
    rst_i = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    #12;
    check("rst_ready", 32'(lookup_ready_o), 32'd1);
    check_idle("rst", 3'd0, 16'd0);
    check("rst_ftaken", 32'(flush_taken_o), 32'd0);
    tick();
    rst_i = 1'b1;

    // Lookup idx 3 then resolve taken: correct prediction, counter saturated
    drive(1'b1, 4'd3, 1'b0, 1'b0);
    check("t1_pred3", 32'(predict_o), 32'd1);
    tick();
    check("t1_count", 32'(queue_count_o), 32'd1);
    drive(1'b0, 4'd3, 1'b1, 1'b1);
    tick();
    check_idle("t1_res", 3'd0, 16'd0);
    check("t1_pred3_after", 32'(predict_o), 32'd1);

    // Two not-taken resolves on idx 5: 11 -> 10 -> 01
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd5, 1'b1, 1'b0);
    tick();
    check("t2_flush1", 32'(flush_o), 32'd1);
    check("t2_ftaken1", 32'(flush_taken_o), 32'd0);
    check("t2_count1", 32'(queue_count_o), 32'd0);
    check("t2_mpcnt1", 32'(mispredict_cnt_o), 32'd1);
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    check("t2_pred5_wt", 32'(predict_o), 32'd1);
    tick();
    check("t2_flush_drop", 32'(flush_o), 32'd0);
    drive(1'b0, 4'd5, 1'b1, 1'b0);
    tick();
    check("t2_flush2", 32'(flush_o), 32'd1);
    check("t2_mpcnt2", 32'(mispredict_cnt_o), 32'd2);
    drive(1'b0, 4'd5, 1'b0, 1'b0);
    check("t2_pred5_wnt", 32'(predict_o), 32'd0);

    // Fill the queue with idx 0..3, then probe backpressure
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0);
      tick();
    end
    check("t3_full_count", 32'(queue_count_o), 32'd4);
    check("t3_full_ready", 32'(lookup_ready_o), 32'd0);
    drive(1'b1, 4'd6, 1'b0, 1'b0);
    tick();
    check("t3_fifth_rej", 32'(queue_count_o), 32'd4);
    // Resolve idx 0 taken (correct) while a push is offered to the full queue
    drive(1'b1, 4'd7, 1'b1, 1'b1);
    tick();
    check("t3_pop_full", 32'(queue_count_o), 32'd3);
    check("t3_no_flush", 32'(flush_o), 32'd0);
    check("t3_ready", 32'(lookup_ready_o), 32'd1);

    // Queue now holds {1,2,3}: resolve idx 1 not taken while idx 4 is offered
    drive(1'b1, 4'd4, 1'b1, 1'b0);
    tick();
    check("t4_flush", 32'(flush_o), 32'd1);
    check("t4_ftaken", 32'(flush_taken_o), 32'd0);
    check("t4_count", 32'(queue_count_o), 32'd0);
    check("t4_mpcnt", 32'(mispredict_cnt_o), 32'd3);
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    check("t4_flush_once", 32'(flush_o), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      drive(1'b0, 4'(i), 1'b0, 1'b0);
      check($sformatf("t4_pred%0d", i), 32'(predict_o), 32'd1);
    end
    // idx 2 must still be strongly taken: one not-taken step keeps predicting taken
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd2, 1'b1, 1'b1);
    tick();
    check("t4_idx2_ok", 32'(flush_o), 32'd0);

    // Resolve with an empty queue
    drive(1'b0, 4'd0, 1'b1, 1'b1);
    tick();
    check("t5_err", 32'(resolve_err_o), 32'd1);
    check("t5_flush", 32'(flush_o), 32'd0);
    check("t5_count", 32'(queue_count_o), 32'd0);
    drive(1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    check("t5_err_drop", 32'(resolve_err_o), 32'd0);
    check("t5_pred0", 32'(predict_o), 32'd1);

    // Flush with a taken redirect: push idx 5 (predicts not taken), resolve taken
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    check("t6_pred5", 32'(predict_o), 32'd0);
    tick();
    drive(1'b0, 4'd5, 1'b1, 1'b1);
    tick();
    check("t6_flush", 32'(flush_o), 32'd1);
    check("t6_ftaken", 32'(flush_taken_o), 32'd1);
    check("t6_mpcnt", 32'(mispredict_cnt_o), 32'd4);
    // table[5] now 10; make it 01 again so reset has something to restore
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    drive(1'b0, 4'd5, 1'b1, 1'b0);
    tick();
    check("t6_mpcnt2", 32'(mispredict_cnt_o), 32'd5);

    // Three outstanding entries, then reset asserted mid-cycle
    for (int i = 8; i < 11; i++) begin
      drive(1'b1, 4'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 4'd5, 1'b0, 1'b0);
    check("t7_pre_count", 32'(queue_count_o), 32'd3);
    check("t7_pre_pred5", 32'(predict_o), 32'd0);
    #2;
    rst_i = 1'b0;
    #1;
    check_idle("t7_rst", 3'd0, 16'd0);
    check("t7_rst_ready", 32'(lookup_ready_o), 32'd1);
    check("t7_rst_pred5", 32'(predict_o), 32'd1);
    tick();
    rst_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(i), 1'b0, 1'b0);
      check($sformatf("t7_pred%0d", i), 32'(predict_o), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("t7_post%0d", i), 3'd0, 16'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
